// File: rtl/spawn_sched_pkg.sv
// Shared types, constants and the round-robin slot picker for the spawn scheduler.
package spawn_sched_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, PICK, STALL} sched_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // First set bit of avail scanning upward from (start % nslot), wrapping to 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] avail, input logic [2:0] start,
                                           input int nslot);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ((int'(start) % nslot) + k) % nslot;
            if ((k < nslot) && !found && avail[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spawn_scheduler_lfsr16.sv
// 16-bit Galois LFSR, free running out of reset; a zero seed is replaced by 1.
module lfsr16
    import spawn_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Shift right, folding the dropped bit back in through the tap mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Paces obstacle spawns across NSLOT engines with an LFSR-randomised tick gap.
// Define SPAWN_SCHED_DIFFICULTY_EN to shrink the gap as spawns accumulate.
module spawn_scheduler
    import spawn_sched_pkg::*;
#(
    parameter int          NSLOT       = 4,
    parameter int          MIN_GAP     = 8,
    parameter logic [7:0]  GAP_MASK    = 8'h0F,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          PEND_TMO    = 4,
    parameter int          RAMP_SPAWNS = 16,
    parameter int          GAP_FLOOR   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             run,
    input  logic [NSLOT-1:0] active,
    output logic [NSLOT-1:0] en,
    output logic [15:0]      spawn_count
);

    localparam int TW = $clog2(PEND_TMO + 1);

    sched_state_t     state_r, state_nxt_s;
    logic [15:0]      lfsr_s;
    logic [8:0]       gap_cnt_r, gap_load_s;
    logic [7:0]       eff_gap_nxt_s;
    logic [NSLOT-1:0] pend_r, avail_s, sel_oh_s, en_r;
    logic [TW-1:0]    pend_tmr_r [NSLOT];
    logic [15:0]      count_r;
    logic [2:0]       sel_s;
    logic             fire_s, load_gap_s, dec_gap_s;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_s)
    );

    assign avail_s    = ~active & ~pend_r;
    assign sel_s      = rr_pick(8'(avail_s), lfsr_s[15:13], NSLOT);
    assign sel_oh_s   = {{(NSLOT-1){1'b0}}, 1'b1} << sel_s;
    assign gap_load_s = {1'b0, eff_gap_nxt_s} + {1'b0, lfsr_s[7:0] & GAP_MASK};

`ifdef SPAWN_SCHED_DIFFICULTY_EN
    localparam int RW = $clog2(RAMP_SPAWNS + 1);
    logic [7:0]    eff_gap_r;
    logic [RW-1:0] ramp_cnt_r, ramp_cnt_nxt_s;

    // Ramp: every RAMP_SPAWNS fires the base gap drops by one down to GAP_FLOOR
    always_comb begin
        eff_gap_nxt_s  = eff_gap_r;
        ramp_cnt_nxt_s = ramp_cnt_r;
        if (fire_s) begin
            if (ramp_cnt_r == RW'(RAMP_SPAWNS - 1)) begin
                ramp_cnt_nxt_s = '0;
                if (eff_gap_r > 8'(GAP_FLOOR)) begin
                    eff_gap_nxt_s = eff_gap_r - 8'd1;
                end else begin
                    eff_gap_nxt_s = eff_gap_r;
                end
            end else begin
                ramp_cnt_nxt_s = ramp_cnt_r + RW'(1);
            end
        end else begin
            eff_gap_nxt_s = eff_gap_r;
        end
    end

    // Ramp state, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eff_gap_r  <= 8'(MIN_GAP);
            ramp_cnt_r <= '0;
        end else begin
            eff_gap_r  <= eff_gap_nxt_s;
            ramp_cnt_r <= ramp_cnt_nxt_s;
        end
    end
`else
    assign eff_gap_nxt_s = 8'(MIN_GAP);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping run always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (!run) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = WAIT;
                WAIT:    state_nxt_s = (tick && (gap_cnt_r == 9'd0)) ? PICK : WAIT;
                PICK:    state_nxt_s = (|avail_s) ? WAIT : STALL;
                STALL:   state_nxt_s = tick ? PICK : STALL;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Per-state control strobes
    always_comb begin
        fire_s     = 1'b0;
        load_gap_s = 1'b0;
        dec_gap_s  = 1'b0;
        if (run) begin
            case (state_r)
                IDLE:    load_gap_s = 1'b1;
                WAIT:    dec_gap_s  = tick && (gap_cnt_r != 9'd0);
                PICK: begin
                    fire_s     = |avail_s;
                    load_gap_s = |avail_s;
                end
                STALL:   fire_s = 1'b0;
                default: fire_s = 1'b0;
            endcase
        end else begin
            fire_s = 1'b0;
        end
    end

    // Gap counter, fire pulse, spawn counter and per-slot pending blockers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_r <= 9'd0;
            en_r      <= '0;
            count_r   <= 16'd0;
            pend_r    <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                pend_tmr_r[i] <= '0;
            end
        end else begin
            if (load_gap_s) begin
                gap_cnt_r <= gap_load_s;
            end else if (dec_gap_s) begin
                gap_cnt_r <= gap_cnt_r - 9'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
            en_r    <= fire_s ? sel_oh_s : '0;
            count_r <= count_r + {15'd0, fire_s};
            // A slot stays blocked until its engine reports busy or the timeout lapses
            for (int i = 0; i < NSLOT; i++) begin
                if (fire_s && (sel_s == 3'(i))) begin
                    pend_r[i]     <= 1'b1;
                    pend_tmr_r[i] <= TW'(PEND_TMO);
                end else if (pend_r[i]) begin
                    if (active[i] || (pend_tmr_r[i] == TW'(1))) begin
                        pend_r[i] <= 1'b0;
                    end else begin
                        pend_tmr_r[i] <= pend_tmr_r[i] - TW'(1);
                    end
                end else begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    assign en          = en_r;
    assign spawn_count = count_r;

endmodule
